// File: rtl/microwave_sequencer_if.sv
// Front-panel and status signals of the microwave cook sequencer.
// master = panel side driving requests, slave = sequencer.
interface microwave_sequencer_if;
    logic        startn;
    logic        stopn;
    logic        clearn;
    logic        door_closed;
    logic        digit_valid;
    logic [3:0]  digit;
    logic        mag;
    logic        timer_done;
    logic [15:0] time_bcd;
    logic [2:0]  state;
    logic        beep;

    modport master (
        output startn, stopn, clearn, door_closed, digit_valid, digit,
        input  mag, timer_done, time_bcd, state, beep
    );

    modport slave (
        input  startn, stopn, clearn, door_closed, digit_valid, digit,
        output mag, timer_done, time_bcd, state, beep
    );
endinterface

// File: rtl/microwave_sequencer.sv
// Cook sequencer: keypad BCD MM:SS entry, 1 Hz countdown, magnetron enable.
// Optional done beep with auto-return to IDLE when MW_DONE_BEEP_EN is defined.
module microwave_sequencer #(
    parameter int unsigned TICK_DIV    = 50_000_000,
    parameter int unsigned BEEP_CYCLES = 1000
) (
    input logic                   clk,
    input logic                   rst,
    microwave_sequencer_if.slave  bus
);
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SET   = 3'd1,
        S_COOK  = 3'd2,
        S_PAUSE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam int unsigned PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

    state_t          r_state;
    logic [15:0]     r_time;
    logic [PW-1:0]   r_presc;
    logic            r_timer_done;
    logic [15:0]     w_dec;
    logic            w_tick;
    logic            w_digit_ok;

`ifdef MW_DONE_BEEP_EN
    localparam int unsigned BW = $clog2(BEEP_CYCLES + 1);
    logic [BW-1:0]   r_beep_cnt;
    logic            r_beep;
`endif

    assign w_tick     = (r_presc == PW'(TICK_DIV - 1));
    assign w_digit_ok = bus.digit_valid && (bus.digit <= 4'd9);

    // BCD MM:SS decrement; seconds wrap 00->59 but larger entered values count down as-is.
    always_comb begin
        w_dec = r_time;
        if (r_time[3:0] != 4'd0) begin
            w_dec[3:0] = r_time[3:0] - 4'd1;
        end else begin
            w_dec[3:0] = 4'd9;
            if (r_time[7:4] != 4'd0) begin
                w_dec[7:4] = r_time[7:4] - 4'd1;
            end else begin
                w_dec[7:4] = 4'd5;
                if (r_time[11:8] != 4'd0) begin
                    w_dec[11:8] = r_time[11:8] - 4'd1;
                end else begin
                    w_dec[11:8]  = 4'd9;
                    w_dec[15:12] = r_time[15:12] - 4'd1;
                end
            end
        end
    end

    // Strict request priority: the highest asserted request consumes the cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_time       <= '0;
            r_presc      <= '0;
            r_timer_done <= 1'b0;
`ifdef MW_DONE_BEEP_EN
            r_beep       <= 1'b0;
            r_beep_cnt   <= '0;
`endif
        end else begin
            r_timer_done <= 1'b0;
`ifdef MW_DONE_BEEP_EN
            r_beep       <= 1'b0;
`endif
            if (!bus.clearn) begin
                r_state <= S_IDLE;
                r_time  <= '0;
            end else begin
                unique case (r_state)
                    S_IDLE: begin
                        if (bus.stopn && bus.startn && w_digit_ok) begin
                            r_time  <= {r_time[11:0], bus.digit};
                            r_state <= S_SET;
                        end
                    end
                    S_SET: begin
                        if (!bus.stopn) begin
                            r_state <= S_IDLE;
                            r_time  <= '0;
                        end else if (!bus.startn) begin
                            if (bus.door_closed && (r_time != '0)) begin
                                r_state <= S_COOK;
                                r_presc <= '0;
                            end
                        end else if (w_digit_ok) begin
                            r_time <= {r_time[11:0], bus.digit};
                        end
                    end
                    S_COOK: begin
                        if (!bus.stopn || !bus.door_closed) begin
                            r_state <= S_PAUSE;
                        end else if (w_tick) begin
                            r_presc <= '0;
                            r_time  <= w_dec;
                            if (w_dec == '0) begin
                                r_state      <= S_DONE;
                                r_timer_done <= 1'b1;
`ifdef MW_DONE_BEEP_EN
                                r_beep       <= 1'b1;
                                r_beep_cnt   <= BW'(BEEP_CYCLES - 1);
`endif
                            end
                        end else begin
                            r_presc <= r_presc + PW'(1);
                        end
                    end
                    S_PAUSE: begin
                        if (!bus.stopn) begin
                            r_state <= S_IDLE;
                            r_time  <= '0;
                        end else if (!bus.startn && bus.door_closed) begin
                            r_state <= S_COOK;
                            r_presc <= '0;
                        end
                    end
                    S_DONE: begin
                        if (!bus.stopn || !bus.door_closed) begin
                            r_state <= S_IDLE;
                            r_time  <= '0;
                        end else if (bus.startn && w_digit_ok) begin
                            r_time  <= {12'h000, bus.digit};
                            r_state <= S_SET;
                        end
`ifdef MW_DONE_BEEP_EN
                        else if (r_beep_cnt == '0) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_beep     <= 1'b1;
                            r_beep_cnt <= r_beep_cnt - BW'(1);
                        end
`endif
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_time  <= '0;
                    end
                endcase
            end
        end
    end

    // Door gating is combinational so opening the door drops mag before the PAUSE edge.
    assign bus.mag        = (r_state == S_COOK) && bus.door_closed;
    assign bus.timer_done = r_timer_done;
    assign bus.time_bcd   = r_time;
    assign bus.state      = r_state;
`ifdef MW_DONE_BEEP_EN
    assign bus.beep       = r_beep;
`else
    assign bus.beep       = 1'b0;
`endif
endmodule

// File: tb/tb_microwave_sequencer.sv
// Self-checking bench: decimal-arithmetic reference model compared every cycle,
// plus directed literal checks for the documented scenarios.
module tb_microwave_sequencer;
    localparam int TD = 4;
    localparam int BC = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    microwave_sequencer_if bus();

    microwave_sequencer #(.TICK_DIV(TD), .BEEP_CYCLES(BC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int tests = 0;
    int fails = 0;

    // Model: time held as a 4-digit decimal number MMSS; states 0..4 as numbered on the port.
    int m_state = 0;
    int m_val   = 0;
    int m_cnt   = 0;
    int m_beep_left = 0;
    bit m_done  = 1'b0;
    bit m_live  = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int to_bcd(input int v);
        return ((v / 1000) % 10) * 4096 + ((v / 100) % 10) * 256 + ((v / 10) % 10) * 16 + (v % 10);
    endfunction

    always @(posedge clk) begin : model
        bit clr, stp, sta, door, dig;
        if (rst) begin
            m_state = 0; m_val = 0; m_cnt = 0; m_done = 1'b0; m_beep_left = 0;
            m_live = 1'b1;
        end else begin
            clr  = !bus.clearn;
            stp  = !bus.stopn;
            sta  = !bus.startn;
            door = bus.door_closed;
            dig  = bus.digit_valid && (bus.digit <= 4'd9);
            m_done = 1'b0;
            if (clr) begin
                m_state = 0; m_val = 0;
            end else begin
                case (m_state)
                    0, 1: begin
                        if (stp) begin
                            m_state = 0; m_val = 0;
                        end else if (sta) begin
                            if (m_state == 1 && door && m_val != 0) begin
                                m_state = 2; m_cnt = 0;
                            end
                        end else if (dig) begin
                            m_val = (m_val * 10 + int'(bus.digit)) % 10000;
                            m_state = 1;
                        end
                    end
                    2: begin
                        if (stp || !door) begin
                            m_state = 3;
                        end else begin
                            m_cnt++;
                            if (m_cnt == TD) begin
                                m_cnt = 0;
                                if (m_val % 100 != 0) m_val = m_val - 1;
                                else m_val = m_val - 100 + 59;
                                if (m_val == 0) begin
                                    m_state = 4; m_done = 1'b1; m_beep_left = BC;
                                end
                            end
                        end
                    end
                    3: begin
                        if (stp) begin
                            m_state = 0; m_val = 0;
                        end else if (sta && door) begin
                            m_state = 2; m_cnt = 0;
                        end
                    end
                    default: begin
                        if (stp || !door) begin
                            m_state = 0; m_val = 0;
                        end else if (!sta && dig) begin
                            m_val = int'(bus.digit); m_state = 1;
                        end else begin
`ifdef MW_DONE_BEEP_EN
                            m_beep_left--;
                            if (m_beep_left == 0) m_state = 0;
`endif
                        end
                    end
                endcase
            end
        end
    end

    always @(negedge clk) begin
        int exp_beep;
        if (m_live) begin
`ifdef MW_DONE_BEEP_EN
            exp_beep = (m_state == 4) ? 1 : 0;
`else
            exp_beep = 0;
`endif
            check("state",      int'(bus.state),      m_state);
            check("time_bcd",   int'(bus.time_bcd),   to_bcd(m_val));
            check("mag",        int'(bus.mag),        (m_state == 2 && bus.door_closed) ? 1 : 0);
            check("timer_done", int'(bus.timer_done), int'(m_done));
            check("beep",       int'(bus.beep),       exp_beep);
        end
    end

    task automatic idle_inputs();
        bus.startn = 1'b1; bus.stopn = 1'b1; bus.clearn = 1'b1;
        bus.door_closed = 1'b1; bus.digit_valid = 1'b0; bus.digit = 4'd0;
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic key(input logic [3:0] d);
        bus.digit_valid = 1'b1; bus.digit = d;
        step(1);
        bus.digit_valid = 1'b0;
    endtask

    task automatic press_start();
        bus.startn = 1'b0;
        step(1);
        bus.startn = 1'b1;
    endtask

    task automatic press_clear();
        bus.clearn = 1'b0;
        step(1);
        bus.clearn = 1'b1;
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        check("rst_state", int'(bus.state), 0);
        check("rst_time", int'(bus.time_bcd), 16'h0000);
        check("rst_mag", int'(bus.mag), 0);
        check("rst_done", int'(bus.timer_done), 0);
        check("rst_beep", int'(bus.beep), 0);

        key(4'd1); key(4'd2); key(4'd3); key(4'd4);
        check("entry_1234", int'(bus.time_bcd), 16'h1234);
        check("entry_state", int'(bus.state), 1);
        check("model_1234", to_bcd(m_val), 16'h1234);
        key(4'hC);
        check("digit_C_ignored", int'(bus.time_bcd), 16'h1234);
        press_clear();
        check("clear_time", int'(bus.time_bcd), 16'h0000);
        check("clear_state", int'(bus.state), 0);

        key(4'd3);
        press_start();
        check("cook_state", int'(bus.state), 2);
        check("cook_mag", int'(bus.mag), 1);
        step(3);
        check("pre_tick_0003", int'(bus.time_bcd), 16'h0003);
        step(1);
        check("tick_0002", int'(bus.time_bcd), 16'h0002);
        step(4);
        check("tick_0001", int'(bus.time_bcd), 16'h0001);
        step(4);
        check("tick_0000", int'(bus.time_bcd), 16'h0000);
        check("done_state", int'(bus.state), 4);
        check("done_pulse", int'(bus.timer_done), 1);
        check("done_mag", int'(bus.mag), 0);
        step(1);
        check("done_pulse_end", int'(bus.timer_done), 0);
`ifdef MW_DONE_BEEP_EN
        check("beep_on", int'(bus.beep), 1);
        step(6);
        check("beep_last", int'(bus.beep), 1);
        check("beep_state", int'(bus.state), 4);
        step(1);
        check("beep_off", int'(bus.beep), 0);
        check("beep_idle", int'(bus.state), 0);
`else
        step(5);
        check("done_held", int'(bus.state), 4);
        check("beep_zero", int'(bus.beep), 0);
        bus.stopn = 1'b0;
        step(1);
        bus.stopn = 1'b1;
        check("done_stop_idle", int'(bus.state), 0);
`endif

        key(4'd1); key(4'd0); key(4'd0);
        press_start();
        step(3);
        check("pre_tick_0100", int'(bus.time_bcd), 16'h0100);
        step(1);
        check("wrap_0059", int'(bus.time_bcd), 16'h0059);
        check("model_0059", to_bcd(m_val), 16'h0059);
        press_clear();

        key(4'd1); key(4'd0);
        press_start();
        step(2);
        bus.door_closed = 1'b0;
        #1;
        check("door_mag_same_cycle", int'(bus.mag), 0);
        check("door_still_cook", int'(bus.state), 2);
        step(1);
        check("pause_state", int'(bus.state), 3);
        step(2);
        check("pause_time_held", int'(bus.time_bcd), 16'h0010);
        bus.door_closed = 1'b1;
        press_start();
        check("resume_state", int'(bus.state), 2);
        check("resume_mag", int'(bus.mag), 1);
        step(3);
        check("resume_held", int'(bus.time_bcd), 16'h0010);
        step(1);
        check("resume_0009", int'(bus.time_bcd), 16'h0009);
        bus.clearn = 1'b0; bus.startn = 1'b0;
        step(1);
        bus.clearn = 1'b1; bus.startn = 1'b1;
        check("clear_wins_state", int'(bus.state), 0);
        check("clear_wins_time", int'(bus.time_bcd), 16'h0000);

        key(4'd5);
        bus.door_closed = 1'b0;
        press_start();
        check("door_open_start", int'(bus.state), 1);
        check("door_open_mag", int'(bus.mag), 0);
        bus.door_closed = 1'b1;
        press_clear();

        repeat (4000) begin
            rst             = ($urandom_range(0, 999) == 0);
            bus.clearn      = ($urandom_range(0, 99) >= 2);
            bus.stopn       = ($urandom_range(0, 99) >= 3);
            bus.startn      = ($urandom_range(0, 99) >= 12);
            bus.door_closed = ($urandom_range(0, 99) >= 5);
            bus.digit_valid = ($urandom_range(0, 99) < 15);
            bus.digit       = 4'($urandom_range(0, 15));
            step(1);
        end
        rst = 1'b0;
        idle_inputs();
        step(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
